// File: rtl/sys_defs.sv
// Shared rename-stage sizing: physical/architectural register counts and the preg index type.
package sys_defs;
  localparam int unsigned NUM_PREG = 64;
  localparam int unsigned NUM_AREG = 32;
  localparam int unsigned PREG_W   = 6;
  localparam int unsigned FL_DEPTH = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0] preg_idx_t;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers feeding rename; slots [tail, head) hold in-flight allocations.
// Optional empty-list retire-to-dispatch bypass enabled by defining FREE_LIST_BYPASS_EN.
module free_list
  import sys_defs::*;
#(
  parameter int unsigned FL_DEPTH = sys_defs::FL_DEPTH,
  parameter int unsigned PREG_W   = sys_defs::PREG_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dispatch_en_i,
  input  logic                            retire_en_i,
  input  logic [PREG_W-1:0]               retire_preg_i,
  input  logic                            recover_en_i,
  output logic [PREG_W-1:0]               free_preg_o,
  output logic                            free_preg_valid_o,
  output logic [$clog2(FL_DEPTH+1)-1:0]   free_cnt_o
);

  localparam int unsigned PTR_W = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0] entry_q [FL_DEPTH];
  logic [PREG_W-1:0] entry_d [FL_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic empty, full, push, pop, bypass;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(FL_DEPTH));
  assign push  = retire_en_i && !full;

`ifdef FREE_LIST_BYPASS_EN
  // An empty list hands the retiring preg straight to dispatch; the slot write is still done so pointers stay aligned.
  assign bypass = empty && retire_en_i;
`else
  assign bypass = 1'b0;
`endif

  assign free_preg_valid_o = !empty || bypass;
  assign free_preg_o       = bypass ? retire_preg_i : entry_q[head_q];
  assign free_cnt_o        = cnt_q;
  assign pop               = dispatch_en_i && free_preg_valid_o;

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;

    if (push) begin
      entry_d[tail_q] = retire_preg_i;
      tail_d          = ptr_inc(tail_q);
    end

    // Push lands before the squash so the excepting instruction's old preg is kept.
    if (recover_en_i) begin
      head_d = tail_d;
      cnt_d  = CNT_W'(FL_DEPTH);
    end else begin
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= PREG_W'(NUM_AREG + i);
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_W'(FL_DEPTH);
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(retire_en_i && full))
        else $error("free_list: push while full, write dropped");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a queue-based model of free and in-flight pregs.
module tb_free_list;
  import sys_defs::*;

`ifdef FREE_LIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dispatch_en_i;
  logic       retire_en_i;
  logic [5:0] retire_preg_i;
  logic       recover_en_i;
  logic [5:0] free_preg_o;
  logic       free_preg_valid_o;
  logic [5:0] free_cnt_o;

  always #5 clk = ~clk;

  free_list #(.FL_DEPTH(32), .PREG_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .dispatch_en_i     (dispatch_en_i),
    .retire_en_i       (retire_en_i),
    .retire_preg_i     (retire_preg_i),
    .recover_en_i      (recover_en_i),
    .free_preg_o       (free_preg_o),
    .free_preg_valid_o (free_preg_valid_o),
    .free_cnt_o        (free_cnt_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // fl: free pregs in pop order; infl: allocated pregs oldest first; arch: committed pregs
  int unsigned fl[$];
  int unsigned infl[$];
  int unsigned arch[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dispatch_en_i = 1'b0;
    retire_en_i   = 1'b0;
    retire_preg_i = '0;
    recover_en_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fl.delete();
    infl.delete();
    arch.delete();
    for (int i = 0; i < 32; i++) begin
      fl.push_back(32 + i);
      arch.push_back(i);
    end
  endtask

  task automatic step(input bit d, input bit r, input int unsigned v, input bit rc);
    bit exp_valid;
    dispatch_en_i = d;
    retire_en_i   = r;
    retire_preg_i = v[5:0];
    recover_en_i  = rc;
    #1;
    exp_valid = (fl.size() > 0) || (BYP && r);
    check_eq("valid", free_preg_valid_o, exp_valid);
    check_eq("cnt", free_cnt_o, fl.size());
    if (exp_valid) check_eq("preg", free_preg_o, (fl.size() > 0) ? fl[0] : v);
    @(posedge clk);
    #1;
    if (r) begin
      fl.push_back(v);
      if (infl.size() > 0) arch.push_back(infl.pop_front());
    end
    if (rc) begin
      fl = {infl, fl};
      infl.delete();
    end else if (d && exp_valid) begin
      infl.push_back(fl.pop_front());
    end
    dispatch_en_i = 1'b0;
    retire_en_i   = 1'b0;
    recover_en_i  = 1'b0;
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int unsigned seen [64];
    int unsigned missing;

    // Reset state
    do_reset();
    check_eq("rst_preg", free_preg_o, 32);
    check_eq("rst_valid", free_preg_valid_o, 1);
    check_eq("rst_cnt", free_cnt_o, 32);

    // Drain, then a pop on an empty list
    pops(32);
    check_eq("drain_valid", free_preg_valid_o, 0);
    check_eq("drain_cnt", free_cnt_o, 0);
    pops(1);
    check_eq("empty_pop_cnt", free_cnt_o, 0);

    // Push latency on an empty list
    step(!BYP, 1'b1, 7, 1'b0);
    check_eq("push_lat_preg", free_preg_o, 7);
    check_eq("push_lat_valid", free_preg_valid_o, 1);
    check_eq("push_lat_cnt", free_cnt_o, 1);

    if (BYP) begin
      pops(1);
      step(1'b1, 1'b1, 9, 1'b0);
      check_eq("byp_cnt", free_cnt_o, 0);
      check_eq("byp_valid", free_preg_valid_o, 0);
    end

    // Pop 5, push 1 and 2, recover
    do_reset();
    pops(5);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    check_eq("rec_cnt", free_cnt_o, 32);
    check_eq("rec_preg", free_preg_o, 34);
    pops(31);
    check_eq("rec_last", free_preg_o, 2);
    pops(1);

    // Same-cycle pop and push at cnt 10
    do_reset();
    pops(22);
    step(1'b1, 1'b1, 5, 1'b0);
    check_eq("pp_cnt", free_cnt_o, 10);
    check_eq("pp_preg", free_preg_o, 55);
    pops(9);
    check_eq("pp_reach", free_preg_o, 5);

    // Recover + push + pop at cnt 20
    do_reset();
    pops(12);
    step(1'b1, 1'b1, 11, 1'b1);
    check_eq("rpp_cnt", free_cnt_o, 32);
    pops(31);
    check_eq("rpp_reach", free_preg_o, 11);

    // Randomized recirculation with pointer wrap
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit d, r, rc;
      int unsigned v;
      d  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 9) < 5) && (fl.size() < 32) && (infl.size() > 0);
      rc = ($urandom_range(0, 39) == 0);
      v  = r ? arch.pop_front() : 0;
      step(d, r, v, rc);
    end

    // Every preg is either free in the DUT or architectural, exactly once
    step(1'b0, 1'b0, 0, 1'b1);
    foreach (seen[i]) seen[i] = 0;
    foreach (arch[i]) seen[arch[i]]++;
    for (int i = 0; i < 32; i++) begin
      #1;
      seen[free_preg_o]++;
      step(1'b1, 1'b0, 0, 1'b0);
    end
    missing = 0;
    foreach (seen[i]) if (seen[i] != 1) missing++;
    check_eq("conserve", missing, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
